// File: rtl/dice_pkg.sv
// Shared constants and helpers for the die-face pixel ROMs.
//   TILE        : die tile edge in pixels
//   PIP_R2      : squared pip radius (boundary inclusive)
//   PIP_LO/MID/HI : pip grid coordinates
//   pip_mask_t  : one bit per pip, bit 0..6 = TL,TR,ML,C,MR,BL,BR
//   face_mask() : active pips for a face value 1..6
//   pip_cx/cy() : centre of pip index 0..6
package dice_pkg;
  localparam int TILE     = 64;
  localparam int PIP_R2   = 25;
  localparam int PIP_LO   = 16;
  localparam int PIP_MID  = 32;
  localparam int PIP_HI   = 48;
  localparam int NUM_PIPS = 7;

  typedef logic [NUM_PIPS-1:0] pip_mask_t;

  function automatic pip_mask_t face_mask(int face);
    pip_mask_t m;
    case (face)
      1:       m = 7'b0001000;  // C
      2:       m = 7'b1000001;  // TL BR
      3:       m = 7'b1001001;  // TL C BR
      4:       m = 7'b1100011;  // TL TR BL BR
      5:       m = 7'b1101011;  // TL TR C BL BR
      6:       m = 7'b1110111;  // TL TR ML MR BL BR
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic int pip_cx(int idx);
    int c;
    case (idx)
      0, 2, 5: c = PIP_LO;
      3:       c = PIP_MID;
      default: c = PIP_HI;
    endcase
    return c;
  endfunction

  function automatic int pip_cy(int idx);
    int c;
    case (idx)
      0, 1:    c = PIP_LO;
      2, 3, 4: c = PIP_MID;
      default: c = PIP_HI;
    endcase
    return c;
  endfunction
endpackage

// File: rtl/dice_pip_hit.sv
// Combinational disc test: hit=1 when (x,y) lies within radius sqrt(PIP_R2)
// of the pip centre (CX,CY), boundary inclusive.
//   x, y : pixel column / row inside the tile (0..63)
//   hit  : pixel belongs to this pip
module dice_pip_hit
  import dice_pkg::*;
#(
  parameter int CX = PIP_MID,
  parameter int CY = PIP_MID
) (
  input  logic [5:0] x,
  input  logic [5:0] y,
  output logic       hit
);
  logic [6:0]  dx, dy;
  logic [5:0]  adx, ady;
  logic [12:0] adx_w, ady_w, d2;

  // Signed 7-bit offsets; squaring the magnitude keeps the math unsigned.
  assign dx    = {1'b0, x} - 7'(CX);
  assign dy    = {1'b0, y} - 7'(CY);
  assign adx   = dx[6] ? 6'(-dx) : dx[5:0];
  assign ady   = dy[6] ? 6'(-dy) : dy[5:0];
  // Widen before multiplying so 63*63*2 cannot overflow.
  assign adx_w = {7'd0, adx};
  assign ady_w = {7'd0, ady};
  assign d2    = adx_w * adx_w + ady_w * ady_w;
  assign hit   = (d2 <= 13'(PIP_R2));
endmodule

// File: rtl/dice_face_rom.sv
// 1-bit 64x64 die-face image ROM with a single output register.
//   FACE  : face value 1..6 drawn by this instance
//   clk   : pixel clock
//   reset : asynchronous active-low reset, clears q
//   addr  : {ignored, row[5:0], col[5:0]}
//   q     : pixel one cycle after addr; 1 = outline/pip, 0 = die body
module dice_face_rom
  import dice_pkg::*;
#(
  parameter int FACE = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] addr,
  output logic        q
);
  if (FACE < 1 || FACE > 6) begin : g_bad_face
    $error("dice_face_rom: FACE=%0d outside 1..6", FACE);
  end

  localparam pip_mask_t MASK = face_mask(FACE);

  logic [5:0]          x, y;
  logic [NUM_PIPS-1:0] hit;
  logic                outline;
  logic                q_d, q_q;
  logic                unused_addr_msb;

  assign x = addr[5:0];
  assign y = addr[11:6];
  // Sign bit of the caller's offset; tile addresses alias on it.
  assign unused_addr_msb = addr[12];

  assign outline = (x == 6'd0) || (x == 6'd63) || (y == 6'd0) || (y == 6'd63);

  for (genvar i = 0; i < NUM_PIPS; i++) begin : g_pip
    dice_pip_hit #(
      .CX(pip_cx(i)),
      .CY(pip_cy(i))
    ) u_pip (
      .x  (x),
      .y  (y),
      .hit(hit[i])
    );
  end

  always_comb begin
    q_d = outline;
    for (int i = 0; i < NUM_PIPS; i++) begin
      q_d = q_d | (hit[i] & MASK[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) q_q <= 1'b0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: tb/tb_dice_face_rom.sv
// Bench for dice_face_rom: FACE=1,2,3 instances share one address stream.
// Expected pixels go into a queue when an address is driven and are popped
// after the edge that should present them.
module tb_dice_face_rom;
  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] addr;
  logic        q1, q2, q3;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];  // {face3, face2, face1}

  dice_face_rom #(.FACE(1)) u_f1 (.clk(clk), .reset(reset), .addr(addr), .q(q1));
  dice_face_rom #(.FACE(2)) u_f2 (.clk(clk), .reset(reset), .addr(addr), .q(q2));
  dice_face_rom #(.FACE(3)) u_f3 (.clk(clk), .reset(reset), .addr(addr), .q(q3));

  always #5 clk = ~clk;

  // Independent reference pixel function.
  function automatic logic golden(int face, int x, int y);
    int cx[7] = '{16, 48, 16, 32, 48, 16, 48};
    int cy[7] = '{16, 16, 32, 32, 32, 48, 48};
    bit on[7];
    on = '{0, 0, 0, 0, 0, 0, 0};
    case (face)
      1: on[3] = 1;
      2: begin on[0] = 1; on[6] = 1; end
      3: begin on[0] = 1; on[3] = 1; on[6] = 1; end
      default: ;
    endcase
    if (x == 0 || x == 63 || y == 0 || y == 63) return 1'b1;
    for (int p = 0; p < 7; p++)
      if (on[p] && ((x - cx[p]) * (x - cx[p]) + (y - cy[p]) * (y - cy[p]) <= 25))
        return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(string tag, logic obs, logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_faces(string tag, logic [2:0] expv);
    check({tag, "_f1"}, q1, expv[0]);
    check({tag, "_f2"}, q2, expv[1]);
    check({tag, "_f3"}, q3, expv[2]);
  endtask

  // One cycle: drive addr mid-cycle, push expectation, compare after the edge.
  task automatic step(string tag, logic [12:0] a, logic [2:0] expv);
    logic [2:0] e;
    @(negedge clk);
    addr = a;
    exp_q.push_back(expv);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_queue: observed empty expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_faces(tag, e);
    end
  endtask

  initial begin
    reset = 1'b1;
    addr  = 13'h0000;
    #1 reset = 1'b0;
    #1 check_faces("reset_init", 3'b000);
    @(negedge clk);
    addr = 13'h0820;
    @(posedge clk);
    #1 check_faces("reset_hold", 3'b000);
    @(negedge clk);
    reset = 1'b1;

    // Centre / corner pips
    step("centre",   13'h0820, 3'b101);
    step("corner",   13'h0410, 3'b110);
    // Radius boundary
    step("rad_x5",   13'h0825, 3'b101);
    step("rad_x6",   13'h0826, 3'b000);
    step("rad_3_4",  13'h0923, 3'b101);
    // Outline and body
    step("origin",   13'h0000, 3'b111);
    step("far_cnr",  13'h0FFF, 3'b111);
    step("body",     13'h0220, 3'b000);

    // Back-to-back stream with bit 12 set on the last address
    step("stream0",  13'h0820, 3'b101);
    step("stream1",  13'h0220, 3'b000);
    step("stream2",  13'h1820, 3'b101);

    // Asynchronous reset mid-stream: q drops without an edge
    @(negedge clk);
    addr = 13'h0820;
    #2 reset = 1'b0;
    #1 check_faces("async_rst", 3'b000);
    @(posedge clk);
    #1 check_faces("rst_low_edge", 3'b000);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 check_faces("rst_release", 3'b101);

    // Full sweep against the reference, bit 12 randomised
    for (int i = 0; i < 4096; i++) begin
      logic [12:0] a;
      logic [2:0]  e;
      a = {1'($urandom_range(0, 1)), 12'(i)};
      e = {golden(3, i % 64, i / 64), golden(2, i % 64, i / 64), golden(1, i % 64, i / 64)};
      step("sweep", a, e);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
